// File: rtl/fpaddsub_issue_arbiter.sv
// fpaddsub_issue_arbiter
//   Shares one fixed-latency FP32 add/sub pipeline between two requesters.
//   One issue per cycle is arbitrated. Operands are registered into the pipe.
//   A tag shift register tracks which requester owns each in-flight op.
//   Each result is steered into the owning requester's FWFT result FIFO.
//   Per-requester credits bound outstanding plus stored results to CREDITS.
//   This means a FIFO never overflows and the pipe never needs to stall.
//
//   Configuration macro: FPADDSUB_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, an eligible req0 always beats req1
//     undefined -> round robin between requesters (default)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op        N=0,1 operation request handshake
//   resN_valid/ready/data/exc      N=0,1 result FIFO head, FWFT
//   pipe_in_valid/a/b/op           registered operands into shared pipe
//   pipe_result/exc                pipe output, aligned with exiting tag
//   busy                           any tag in flight or any FIFO non-empty
module fpaddsub_issue_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [31:0] res0_data,
  output logic [4:0]  res0_exc,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [31:0] res1_data,
  output logic [4:0]  res1_exc,
  output logic        pipe_in_valid,
  output logic [31:0] pipe_a,
  output logic [31:0] pipe_b,
  output logic        pipe_op,
  input  logic [31:0] pipe_result,
  input  logic [4:0]  pipe_exc,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned XW = 5;
  localparam int unsigned EW = DW + XW;
  localparam int unsigned PW = $clog2(CREDITS);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic [1:0]    req_valid;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    res_ready;
  logic [1:0]    push;
  logic [1:0]    pop;

  logic [CW-1:0] credit_q [2];
  logic [CW-1:0] credit_d [2];
  logic [CW-1:0] cnt_q    [2];
  logic [CW-1:0] cnt_d    [2];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [EW-1:0] mem_q    [2][CREDITS];

  logic          tag_vld_q [LATENCY];
  logic          tag_vld_d [LATENCY];
  logic          tag_id_q  [LATENCY];
  logic          tag_id_d  [LATENCY];
  logic          tag_any;

  logic          pipe_vld_q, pipe_vld_d;
  logic [DW-1:0] pipe_a_q, pipe_a_d;
  logic [DW-1:0] pipe_b_q, pipe_b_d;
  logic          pipe_op_q, pipe_op_d;

  logic          exit_vld;
  logic          exit_id;
  logic [EW-1:0] push_word;

`ifndef FPADDSUB_ARB_FIXED_PRIO_EN
  // 1 = req1 granted last; reset to 1 so req0 wins the first tie
  logic last_grant_q, last_grant_d;
`endif

  // Arbitration: eligibility needs a free credit; nothing granted in reset
  always_comb begin
    req_valid = {req1_valid, req0_valid};
    elig      = '0;
    grant     = '0;
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] & (credit_q[n] != '0) & ~rst;
    end
`ifdef FPADDSUB_ARB_FIXED_PRIO_EN
    if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
`else
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
    last_grant_d = (grant != 2'b00) ? grant[1] : last_grant_q;
`endif
  end

  // Operand register, tag shift register, FIFO pointers and credits
  always_comb begin
    pipe_vld_d = |grant;
    pipe_a_d   = pipe_a_q;
    pipe_b_d   = pipe_b_q;
    pipe_op_d  = pipe_op_q;
    if (grant[1]) begin
      pipe_a_d  = req1_a;
      pipe_b_d  = req1_b;
      pipe_op_d = req1_op;
    end else if (grant[0]) begin
      pipe_a_d  = req0_a;
      pipe_b_d  = req0_b;
      pipe_op_d = req0_op;
    end

    tag_vld_d[0] = |grant;
    tag_id_d[0]  = grant[1];
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    tag_any = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      tag_any = tag_any | tag_vld_q[i];
    end

    // The last tag stage lines up with the pipe output. A result with no valid tag is dropped.
    exit_vld  = tag_vld_q[LATENCY-1];
    exit_id   = tag_id_q[LATENCY-1];
    push_word = {pipe_exc, pipe_result};
    push      = {exit_vld & exit_id, exit_vld & ~exit_id};
    res_ready = {res1_ready, res0_ready};

    for (int n = 0; n < 2; n++) begin
      pop[n]      = (cnt_q[n] != '0) & res_ready[n];
      cnt_d[n]    = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
      wr_ptr_d[n] = wr_ptr_q[n] + PW'(push[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + PW'(pop[n]);
      credit_d[n] = credit_q[n] - CW'(grant[n]) + CW'(pop[n]);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= 1'b0;
      pipe_a_q   <= '0;
      pipe_b_q   <= '0;
      pipe_op_q  <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= CW'(CREDITS);
        cnt_q[n]    <= '0;
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
`ifndef FPADDSUB_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_a_q   <= pipe_a_d;
      pipe_b_q   <= pipe_b_d;
      pipe_op_q  <= pipe_op_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_d[i];
        tag_id_q[i]  <= tag_id_d[i];
      end
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= credit_d[n];
        cnt_q[n]    <= cnt_d[n];
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
      end
`ifndef FPADDSUB_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care while a FIFO is empty
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n] && !rst) begin
        mem_q[n][wr_ptr_q[n]] <= push_word;
      end
    end
  end

  assign req0_ready    = grant[0];
  assign req1_ready    = grant[1];
  assign pipe_in_valid = pipe_vld_q;
  assign pipe_a        = pipe_a_q;
  assign pipe_b        = pipe_b_q;
  assign pipe_op       = pipe_op_q;

  // Head data is forced to zero when empty so reset and idle outputs are clean
  assign res0_valid = (cnt_q[0] != '0);
  assign res1_valid = (cnt_q[1] != '0);
  assign res0_data  = res0_valid ? mem_q[0][rd_ptr_q[0]][DW-1:0]  : '0;
  assign res0_exc   = res0_valid ? mem_q[0][rd_ptr_q[0]][EW-1:DW] : '0;
  assign res1_data  = res1_valid ? mem_q[1][rd_ptr_q[1]][DW-1:0]  : '0;
  assign res1_exc   = res1_valid ? mem_q[1][rd_ptr_q[1]][EW-1:DW] : '0;

  assign busy = tag_any | res0_valid | res1_valid;

endmodule

// File: tb/tb_fpaddsub_issue_arbiter.sv
// Bench for fpaddsub_issue_arbiter: a behavioural stand-in for the shared pipe,
// plus per-requester expected-result queues filled on accept and drained on pop.
module tb_fpaddsub_issue_arbiter;

  localparam int unsigned LAT  = 4;
  localparam int unsigned CRED = 4;
  localparam logic [31:0] QNAN = 32'h7FC00000;
`ifdef FPADDSUB_ARB_FIXED_PRIO_EN
  localparam int N_TIE = 4;
`else
  localparam int N_TIE = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        res0_valid, res0_ready, res1_valid, res1_ready;
  logic [31:0] res0_data, res1_data;
  logic [4:0]  res0_exc, res1_exc;
  logic        pipe_in_valid, pipe_op;
  logic [31:0] pipe_a, pipe_b, pipe_result;
  logic [4:0]  pipe_exc;
  logic        busy;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [36:0] exp_q0[$];
  logic [36:0] exp_q1[$];
  logic [36:0] w0, w1;

  fpaddsub_issue_arbiter #(.LATENCY(LAT), .CREDITS(CRED)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data), .res0_exc(res0_exc),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data), .res1_exc(res1_exc),
    .pipe_in_valid(pipe_in_valid), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_op(pipe_op),
    .pipe_result(pipe_result), .pipe_exc(pipe_exc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in arithmetic: any deterministic function of the operands will do
  function automatic logic [36:0] pipe_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] r;
    logic [4:0]  x;
    r = op ? a - b : a + b;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) x = 5'b11000;
    else x = {1'b0, a[3:0] ^ b[3:0]};
    return {x, r};
  endfunction

  // Pipe model: result appears in the cycle the DUT's last tag stage is valid
  logic [36:0] pm_word [LAT-1];
  logic        pm_vld  [LAT-1];
  always @(posedge clk) begin
    pm_vld[0]  <= pipe_in_valid;
    pm_word[0] <= pipe_fn(pipe_a, pipe_b, pipe_op);
    for (int i = 1; i < LAT - 1; i++) begin
      pm_vld[i]  <= pm_vld[i-1];
      pm_word[i] <= pm_word[i-1];
    end
  end
  assign pipe_result = pm_vld[LAT-2] ? pm_word[LAT-2][31:0]  : 32'hDEADBEEF;
  assign pipe_exc    = pm_vld[LAT-2] ? pm_word[LAT-2][36:32] : 5'h1F;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  // Scoreboard: push expected result on accept, compare on pop
  always @(negedge clk) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(pipe_fn(req0_a, req0_b, req0_op));
        chk("credit0_bound", 64'(exp_q0.size() <= CRED), 64'd1);
      end
      if (req1_valid && req1_ready) begin
        exp_q1.push_back(pipe_fn(req1_a, req1_b, req1_op));
        chk("credit1_bound", 64'(exp_q1.size() <= CRED), 64'd1);
      end
      if (res0_valid && res0_ready) begin
        chk("res0_pending", 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) begin
          w0 = exp_q0.pop_front();
          chk("res0_data", 64'(res0_data), 64'(w0[31:0]));
          chk("res0_exc", 64'(res0_exc), 64'(w0[36:32]));
        end
      end
      if (res1_valid && res1_ready) begin
        chk("res1_pending", 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) begin
          w1 = exp_q1.pop_front();
          chk("res1_data", 64'(res1_data), 64'(w1[31:0]));
          chk("res1_exc", 64'(res1_exc), 64'(w1[36:32]));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_issue;
    int   k;
    int   acc;
    logic exp0;
    logic seen;
    logic [36:0] ew;

    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    res0_ready = 1'b0; res1_ready = 1'b0;

    // Reset state, with requests held high during reset
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_pipe_in_valid", 64'(pipe_in_valid), 64'd0);
    chk("rst_pipe_a", 64'(pipe_a), 64'd0);
    chk("rst_res0_valid", 64'(res0_valid), 64'd0);
    chk("rst_res1_valid", 64'(res1_valid), 64'd0);
    chk("rst_res0_data", 64'(res0_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // Single op from req0
    tick();
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = 1'b0;
    @(negedge clk);
    chk("single_grant", 64'(req0_ready), 64'd1);
    t_issue = cyc;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_pipe_valid", 64'(pipe_in_valid), 64'd1);
    chk("single_pipe_a", 64'(pipe_a), 64'h3F800000);
    chk("single_pipe_b", 64'(pipe_b), 64'h40000000);
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    chk("single_pipe_valid_drop", 64'(pipe_in_valid), 64'd0);
    chk("single_pipe_a_hold", 64'(pipe_a), 64'h3F800000);
    k = 0;
    while (!res0_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("single_latency", 64'(cyc - t_issue), 64'(LAT + 1));
    ew = pipe_fn(32'h3F800000, 32'h40000000, 1'b0);
    chk("single_res0_data", 64'(res0_data), 64'(ew[31:0]));
    chk("single_res1_quiet", 64'(res1_valid), 64'd0);
    tick();
    res0_ready = 1'b1;
    tick();
    res0_ready = 1'b0;
    @(negedge clk);
    chk("single_res0_popped", 64'(res0_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);

    // Tie: req0 was granted last, so round robin starts with req1
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; res0_ready = 1'b1; res1_ready = 1'b1;
`ifdef FPADDSUB_ARB_FIXED_PRIO_EN
    exp0 = 1'b1;
`else
    exp0 = 1'b0;
`endif
    for (int i = 0; i < N_TIE; i++) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom_range(0, 1));
      req1_a = $urandom; req1_b = $urandom; req1_op = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("tie_g0", 64'(req0_ready), 64'(exp0));
      chk("tie_g1", 64'(req1_ready), 64'(!exp0));
`ifndef FPADDSUB_ARB_FIXED_PRIO_EN
      exp0 = !exp0;
`endif
      tick();
    end
    drain("tie_drain");

    // Credit exhaustion on req0: four accepts, then stalled
    tick();
    res0_ready = 1'b0; res1_ready = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("cred_accept", 64'(req0_ready), 64'(i < 4));
      tick();
    end
    res0_ready = 1'b1;
    @(negedge clk);
    chk("cred_pop_cycle_ready", 64'(req0_ready), 64'd0);
    chk("cred_pop_cycle_valid", 64'(res0_valid), 64'd1);
    tick();
    res0_ready = 1'b0;
    @(negedge clk);
    chk("cred_one_more", 64'(req0_ready), 64'd1);
    tick();
    req0_a = $urandom;
    @(negedge clk);
    chk("cred_zero_again", 64'(req0_ready), 64'd0);
    drain("cred_drain");

    // Push and pop in the same cycle with two results stored
    tick();
    res0_ready = 1'b0; res1_ready = 1'b0;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 1'b0;
    @(negedge clk);
    chk("pp_g0", 64'(req0_ready), 64'd1);
    tick();
    req0_a = $urandom; req0_b = $urandom; req0_op = 1'b1;
    @(negedge clk);
    chk("pp_g1", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 1'b0;
    @(negedge clk);
    chk("pp_g2", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pp_two_stored", 64'(res0_valid), 64'd1);
    tick();
    res0_ready = 1'b1;
    @(negedge clk);
    chk("pp_pop_valid", 64'(res0_valid), 64'd1);
    tick();
    res0_ready = 1'b0;
    tick();
    res0_ready = 1'b1;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (!res0_valid) break;
      k++;
      tick();
    end
    chk("pp_occupancy", 64'(k), 64'd2);
    drain("pp_drain");

    // NaN operand on req1: exception vector routed to requester 1 only
    tick();
    res0_ready = 1'b1; res1_ready = 1'b1;
    req1_valid = 1'b1; req1_a = QNAN; req1_b = 32'h3F800000; req1_op = 1'b0;
    @(negedge clk);
    chk("exc_grant", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    k = 0;
    while (!res1_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("exc_res1_valid", 64'(res1_valid), 64'd1);
    chk("exc_res1_exc", 64'(res1_exc), 64'b11000);
    chk("exc_res0_quiet", 64'(res0_valid), 64'd0);
    drain("exc_drain");

    // Reset with three ops in flight
    tick();
    res0_ready = 1'b1; res1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_mid_req1_ready", 64'(req1_ready), 64'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (res0_valid || res1_valid) seen = 1'b1;
    end
    chk("rst_mid_no_results", 64'(seen), 64'd0);
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h40400000; req0_b = 32'h3F800000; req0_op = 1'b1;
    req1_a = 32'h40800000; req1_b = 32'h40000000; req1_op = 1'b0;
    @(negedge clk);
    chk("rst_mid_first_tie", 64'(req0_ready), 64'd1);
    tick();
    @(negedge clk);
`ifdef FPADDSUB_ARB_FIXED_PRIO_EN
    chk("rst_mid_second_tie", 64'(req0_ready), 64'd1);
`else
    chk("rst_mid_second_tie", 64'(req1_ready), 64'd1);
`endif
    drain("rst_mid_drain");

    // Credits are full again: exactly CREDITS accepts with no pops
    tick();
    res0_ready = 1'b0; req0_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req0_a = $urandom; req0_b = $urandom;
      @(negedge clk);
      if (req0_ready) acc++;
      tick();
    end
    chk("post_rst_credits", 64'(acc), 64'(CRED));
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
